// File: rtl/fnd_share_arbiter.sv
// fnd_share_arbiter
//   Shares one FND display between two requesters. A granted value is held
//   on the display for HOLD_CYCLES clock cycles; at the end of a hold the
//   other requester is preferred, so continuous dual requests alternate.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        asynchronous active-low reset
//   req0, data0  requester 0 request and value (value sampled at grant only)
//   ack0         one-cycle pulse when requester 0 is granted
//   req1, data1  requester 1 request and value
//   ack1         one-cycle pulse when requester 1 is granted
//   number       registered value for the FND controller
//   owner        registered owner code: 00 none, 01 src0, 10 src1
module fnd_share_arbiter #(
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic [7:0] number,
    output logic [1:0] owner
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD0,
        HOLD1
    } state_t;

    localparam logic [31:0] RELOAD = 32'(HOLD_CYCLES - 1);

    state_t      state, state_n;
    logic [31:0] timer, timer_n;
    logic        last_grant, last_grant_n;
    logic [7:0]  number_n;
    logic [1:0]  owner_n;
    logic        ack0_n, ack1_n;
    logic        grant0, grant1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= '0;
            last_grant <= 1'b1;
            number     <= '0;
            owner      <= 2'b00;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            last_grant <= last_grant_n;
            number     <= number_n;
            owner      <= owner_n;
            ack0       <= ack0_n;
            ack1       <= ack1_n;
        end
    end

    always_comb begin
        state_n      = state;
        timer_n      = timer;
        last_grant_n = last_grant;
        number_n     = number;
        owner_n      = owner;
        ack0_n       = 1'b0;
        ack1_n       = 1'b0;
        grant0       = 1'b0;
        grant1       = 1'b0;

        if (state != IDLE && timer != '0) begin
            // Mid-hold: requests are ignored, display is frozen.
            timer_n = timer - 32'd1;
        end else begin
            // Decision point (IDLE, or final cycle of a hold). On a tie the
            // source that did not win last time is chosen; while holding x,
            // last_grant==x, so this also hands over to the other source.
            grant0 = req0 && (!req1 || last_grant);
            grant1 = req1 && (!req0 || !last_grant);

            if (grant0) begin
                state_n      = HOLD0;
                timer_n      = RELOAD;
                last_grant_n = 1'b0;
                number_n     = data0;
                owner_n      = 2'b01;
                ack0_n       = 1'b1;
            end else if (grant1) begin
                state_n      = HOLD1;
                timer_n      = RELOAD;
                last_grant_n = 1'b1;
                number_n     = data1;
                owner_n      = 2'b10;
                ack1_n       = 1'b1;
            end else begin
                state_n = IDLE;
                owner_n = 2'b00;
            end
        end
    end

endmodule
